// File: rtl/shot_clock_pkg.sv
// -----------------------------------------------------------------------------
// shot_clock_pkg
// Shared constants for the shot-clock sequencing controller:
//   - FSM state codes (LOAD/IDLE/RUN/PAUSED/EXPIRED), 3-bit legacy encoding
//   - default preset load values (24 s / 30 s)
//   - countdown value width
// -----------------------------------------------------------------------------
package shot_clock_pkg;

    localparam int CNT_W        = 5;
    localparam int STATE_W      = 3;

    localparam int PRESET_A_DEF = 24;
    localparam int PRESET_B_DEF = 30;

    localparam logic [STATE_W-1:0] ST_LOAD    = 3'd0;
    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd1;
    localparam logic [STATE_W-1:0] ST_RUN     = 3'd2;
    localparam logic [STATE_W-1:0] ST_PAUSED  = 3'd3;
    localparam logic [STATE_W-1:0] ST_EXPIRED = 3'd4;

endpackage

// File: rtl/shot_clock_ctrl_btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
// Conditions one raw active-low pushbutton: two-flop synchronizer, debounce
// counter, and a one-cycle press pulse on the accepted 1->0 transition.
//
// Parameters:
//   DEBOUNCE_CYC  consecutive equal synchronized samples needed to accept a
//                 new level (>= 1)
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous, active-low reset
//   btn_n  in   raw pushbutton, active-low, asynchronous to clk
//   press  out  registered one-cycle pulse per accepted press
// -----------------------------------------------------------------------------
module btn_conditioner #(
    parameter int DEBOUNCE_CYC = 500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic press
);

    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

    logic            sync_1;
    logic            sync_2;
    logic            db_level;    // accepted (debounced) button level
    logic            db_level_q;  // previous accepted level, for edge detect
    logic [DB_W-1:0] db_cnt;

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values; blocking here would collapse the synchronizer chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_1     <= 1'b1;
            sync_2     <= 1'b1;
            db_level   <= 1'b1;
            db_level_q <= 1'b1;
            db_cnt     <= '0;
            press      <= 1'b0;
        end else begin
            sync_1 <= btn_n;
            sync_2 <= sync_1;

            // Count consecutive samples that disagree with the accepted level;
            // any agreeing sample restarts the run.
            if (sync_2 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_level <= sync_2;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end

            db_level_q <= db_level;
            press      <= db_level_q & ~db_level;
        end
    end

endmodule

// File: rtl/shot_clock_ctrl.sv
// -----------------------------------------------------------------------------
// shot_clock_ctrl
// Sequencing controller for the 24/30 s shot-clock countdown datapath.
// Conditions the three pushbuttons, generates the 1 Hz decrement strobe and
// runs the LOAD/IDLE/RUN/PAUSED/EXPIRED state machine. The countdown register
// itself lives downstream and is fed back through cnt_value.
//
// Optional feature macro: SHOT_CLOCK_BLINK_EN
//   defined     -> disp_blank blinks (half period TICK_DIV/2) while EXPIRED
//   not defined -> disp_blank tied to 0, no blink counter
//
// Parameters:
//   TICK_DIV      clk cycles per second (even, >= 4)
//   DEBOUNCE_CYC  button debounce length in cycles
//   BUZZ_SEC      buzzer duration after expiry, seconds
//   PRESET_A/B    load values for sw_sel = 0 / 1 (1..31)
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   start_n        raw start button, active-low
//   pause_n        raw pause button, active-low
//   load_n         raw load button, active-low
//   sw_sel         preset select switch (asynchronous)
//   cnt_value      current countdown value from the datapath
//   cnt_load       one-cycle strobe: datapath loads cnt_load_val
//   cnt_load_val   preset value, valid while cnt_load = 1
//   cnt_dec        one-cycle strobe: datapath decrements by 1
//   buzzer         horn drive
//   disp_blank     display blank request
//   run_led        high while in RUN
//   state          current FSM state code
// -----------------------------------------------------------------------------
module shot_clock_ctrl
    import shot_clock_pkg::*;
#(
    parameter int TICK_DIV     = 50_000_000,
    parameter int DEBOUNCE_CYC = 500_000,
    parameter int BUZZ_SEC     = 2,
    parameter int PRESET_A     = PRESET_A_DEF,
    parameter int PRESET_B     = PRESET_B_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_n,
    input  logic               pause_n,
    input  logic               load_n,
    input  logic               sw_sel,
    input  logic [CNT_W-1:0]   cnt_value,
    output logic               cnt_load,
    output logic [CNT_W-1:0]   cnt_load_val,
    output logic               cnt_dec,
    output logic               buzzer,
    output logic               disp_blank,
    output logic               run_led,
    output logic [STATE_W-1:0] state
);

    localparam int PRESC_W  = $clog2(TICK_DIV);
    localparam int BUZZ_CYC = BUZZ_SEC * TICK_DIV;
    localparam int BUZZ_W   = $clog2(BUZZ_CYC + 1);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [BUZZ_W-1:0]  BUZZ_LAST  = BUZZ_W'(BUZZ_CYC - 1);
    localparam logic [CNT_W-1:0]   LOAD_A     = CNT_W'(PRESET_A);
    localparam logic [CNT_W-1:0]   LOAD_B     = CNT_W'(PRESET_B);

    logic               start_press;
    logic               pause_press;
    logic               load_press;
    logic               sw_meta;
    logic               sw_sync;
    logic [PRESC_W-1:0] presc;
    logic               tick;
    logic [STATE_W-1:0] state_nx;
    logic               entering_expired;
    logic [BUZZ_W-1:0]  buzz_cnt;

    // ---------------------------------------------------------------- inputs
    btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_start (
        .clk   (clk),
        .reset (reset),
        .btn_n (start_n),
        .press (start_press)
    );

    btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_pause (
        .clk   (clk),
        .reset (reset),
        .btn_n (pause_n),
        .press (pause_press)
    );

    btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_load (
        .clk   (clk),
        .reset (reset),
        .btn_n (load_n),
        .press (load_press)
    );

    // NOTE: the switch synchronizer is deliberately left without reset so it
    // keeps tracking sw_sel while reset is held; the load issued on the first
    // cycle after release then already sees the real switch position.
    always_ff @(posedge clk) begin
        sw_meta <= sw_sel;
        sw_sync <= sw_meta;
    end

    // ------------------------------------------------------------------- FSM
    assign tick = (state == ST_RUN) && (presc == PRESC_LAST);

    // NOTE: state_nx gets its default before the case so every path assigns
    // it; a missing default would infer a latch.
    always_comb begin
        state_nx = state;
        if (load_press) begin
            state_nx = ST_LOAD;
        end else begin
            case (state)
                ST_LOAD:    state_nx = ST_IDLE;
                ST_IDLE:    if (start_press) state_nx = ST_RUN;
                ST_RUN: begin
                    // Expiry on a tick beats a simultaneous pause.
                    if (tick && (cnt_value <= CNT_W'(1))) state_nx = ST_EXPIRED;
                    else if (pause_press)                 state_nx = ST_PAUSED;
                end
                ST_PAUSED:  if (start_press || pause_press) state_nx = ST_RUN;
                ST_EXPIRED: state_nx = ST_EXPIRED;
                default:    state_nx = ST_LOAD;
            endcase
        end
    end

    assign entering_expired = (state_nx == ST_EXPIRED) && (state != ST_EXPIRED);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_LOAD;
            presc        <= '0;
            cnt_load     <= 1'b0;
            cnt_load_val <= LOAD_A;
            cnt_dec      <= 1'b0;
            run_led      <= 1'b0;
        end else begin
            state   <= state_nx;
            run_led <= (state_nx == ST_RUN);

            // The load strobe is issued on the edge that leaves LOAD, so the
            // reset state itself produces the power-up load.
            cnt_load <= (state == ST_LOAD);
            if (state == ST_LOAD) begin
                cnt_load_val <= sw_sync ? LOAD_B : LOAD_A;
            end

            // cnt_value == 0 expires without a decrement; a load press
            // supersedes a tick landing in the same cycle.
            cnt_dec <= tick && !load_press && (cnt_value != '0);

            // Resuming from PAUSED keeps the partial second.
            if ((state_nx == ST_LOAD) || ((state == ST_IDLE) && (state_nx == ST_RUN))) begin
                presc <= '0;
            end else if (state == ST_RUN) begin
                presc <= tick ? '0 : presc + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- buzzer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buzzer   <= 1'b0;
            buzz_cnt <= '0;
        end else if (entering_expired) begin
            buzzer   <= 1'b1;
            buzz_cnt <= BUZZ_LAST;
        end else if (state_nx != ST_EXPIRED) begin
            buzzer   <= 1'b0;
            buzz_cnt <= '0;
        end else if (buzzer) begin
            if (buzz_cnt == '0) buzzer   <= 1'b0;
            else                buzz_cnt <= buzz_cnt - 1'b1;
        end
    end

    // ----------------------------------------------------------------- blink
`ifdef SHOT_CLOCK_BLINK_EN
    localparam int BLINK_HALF = TICK_DIV / 2;
    localparam int BLINK_W    = $clog2(BLINK_HALF);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    logic [BLINK_W-1:0] blink_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp_blank <= 1'b0;
            blink_cnt  <= '0;
        end else if (entering_expired) begin
            disp_blank <= 1'b1;
            blink_cnt  <= '0;
        end else if (state_nx != ST_EXPIRED) begin
            disp_blank <= 1'b0;
            blink_cnt  <= '0;
        end else if (blink_cnt == BLINK_LAST) begin
            disp_blank <= ~disp_blank;
            blink_cnt  <= '0;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end
`else
    assign disp_blank = 1'b0;
`endif

endmodule

// File: tb/tb_shot_clock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shot_clock_ctrl
// Directed self-checking bench for shot_clock_ctrl with TICK_DIV=10,
// DEBOUNCE_CYC=4, BUZZ_SEC=2. The countdown datapath is emulated inside the
// bench and fed back on cnt_value. Buttons are tapped low for 10 cycles and
// released automatically. Observe-and-drive happens on the falling edge.
// -----------------------------------------------------------------------------
module tb_shot_clock_ctrl;

    localparam logic [2:0] S_LOAD    = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_RUN     = 3'd2;
    localparam logic [2:0] S_PAUSED  = 3'd3;
    localparam logic [2:0] S_EXPIRED = 3'd4;

    // Hand-derived latencies for DEBOUNCE_CYC=4: 2 sync + 4 debounce +
    // 1 pulse + 1 state edge.
    localparam int PRESS_LAT = 8;

    logic       clk;
    logic       reset;
    logic       start_n;
    logic       pause_n;
    logic       load_n;
    logic       sw_sel;
    logic [4:0] cnt_value;
    logic       cnt_load;
    logic [4:0] cnt_load_val;
    logic       cnt_dec;
    logic       buzzer;
    logic       disp_blank;
    logic       run_led;
    logic [2:0] state;

    shot_clock_ctrl #(
        .TICK_DIV     (10),
        .DEBOUNCE_CYC (4),
        .BUZZ_SEC     (2),
        .PRESET_A     (24),
        .PRESET_B     (30)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_n      (start_n),
        .pause_n      (pause_n),
        .load_n       (load_n),
        .sw_sel       (sw_sel),
        .cnt_value    (cnt_value),
        .cnt_load     (cnt_load),
        .cnt_load_val (cnt_load_val),
        .cnt_dec      (cnt_dec),
        .buzzer       (buzzer),
        .disp_blank   (disp_blank),
        .run_led      (run_led),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_total = 0;
    int         n_pass  = 0;
    int         n_fail  = 0;

    logic [4:0] model = 5'd0;
    int         dec_count    = 0;
    int         dec_in_pause = 0;
    int         run_rises    = 0;
    logic       run_q        = 1'b0;
    int         st_hold = 0;
    int         pa_hold = 0;
    int         ld_hold = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: observe outputs, update the datapath model and the auto
    // release of tapped buttons.
    task automatic step();
        @(negedge clk);
        if (st_hold > 0) begin st_hold--; if (st_hold == 0) start_n = 1'b1; end
        if (pa_hold > 0) begin pa_hold--; if (pa_hold == 0) pause_n = 1'b1; end
        if (ld_hold > 0) begin ld_hold--; if (ld_hold == 0) load_n  = 1'b1; end
        if (cnt_load) begin
            model = cnt_load_val;
        end else if (cnt_dec) begin
            model = model - 5'd1;
        end
        if (cnt_dec) begin
            dec_count++;
            if (state == S_PAUSED) dec_in_pause++;
        end
        if (run_led && !run_q) run_rises++;
        run_q     = run_led;
        cnt_value = model;
    endtask

    task automatic tap(input int which);
        case (which)
            0:       begin start_n = 1'b0; st_hold = 10; end
            1:       begin pause_n = 1'b0; pa_hold = 10; end
            default: begin load_n  = 1'b0; ld_hold = 10; end
        endcase
    endtask

    task automatic wait_state(input logic [2:0] s, input int max_cyc, output int cyc);
        cyc = 0;
        while (state !== s && cyc < max_cyc) begin
            step();
            cyc++;
        end
    endtask

    task automatic wait_dec(output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (cnt_dec !== 1'b1 && cyc < 60);
    endtask

    int n;
    int k;
    int d0;
    int d_run;
    int blen;
    int bad_buzz;
    int bad_blank;
    logic exp_blank;

    initial begin
        reset     = 1'b0;
        start_n   = 1'b1;
        pause_n   = 1'b1;
        load_n    = 1'b1;
        sw_sel    = 1'b1;
        cnt_value = 5'd0;

        // ---- reset values
        repeat (3) step();
        check("rst_state",    state,        S_LOAD);
        check("rst_cnt_load", cnt_load,     0);
        check("rst_load_val", cnt_load_val, 24);
        check("rst_cnt_dec",  cnt_dec,      0);
        check("rst_buzzer",   buzzer,       0);
        check("rst_blank",    disp_blank,   0);
        check("rst_run_led",  run_led,      0);

        // ---- reset release with sw_sel=1: one load of 30, then IDLE
        reset = 1'b1;
        step();
        check("por_cnt_load", cnt_load,     1);
        check("por_load_val", cnt_load_val, 30);
        check("por_state",    state,        S_IDLE);
        step();
        check("por_load_once", cnt_load,    0);
        check("por_model",     model,       30);

        // ---- load press with sw_sel=0 reloads 24
        sw_sel = 1'b0;
        repeat (3) step();
        tap(2);
        wait_state(S_LOAD, 40, n);
        check("load_lat", n, PRESS_LAT);
        step();
        check("load_cnt_load", cnt_load,     1);
        check("load_val_24",   cnt_load_val, 24);
        check("load_to_idle",  state,        S_IDLE);
        repeat (20) step();
        check("load_model", model, 24);

        // ---- start: first strobe 10 cycles after RUN, then every 10
        d_run = dec_count;
        tap(0);
        wait_state(S_RUN, 40, n);
        check("start_lat",  n,       PRESS_LAT);
        check("run_led_on", run_led, 1);
        wait_dec(n);
        check("first_dec", n, 10);
        wait_dec(n);
        check("dec_interval", n, 10);

        // ---- pause 4 cycles into a second, hold 50 cycles, resume
        repeat (6) step();
        tap(1);
        k = 6;
        n = 0;
        while (state !== S_PAUSED && n < 40) begin
            step();
            n++;
            k++;
            if (cnt_dec) k = 0;
        end
        check("pause_state", state, S_PAUSED);
        check("pause_phase", k,     4);
        d0 = dec_count;
        repeat (50) step();
        check("paused_no_dec",  dec_count - d0, 0);
        check("paused_hold",    state,          S_PAUSED);
        check("paused_run_led", run_led,        0);
        tap(1);
        wait_state(S_RUN, 40, n);
        check("resume_lat", n, PRESS_LAT);
        wait_dec(n);
        check("resume_dec", n, 6);

        // ---- run to expiry: 24 strobes in total, buzzer 20 cycles
        wait_state(S_EXPIRED, 400, n);
        check("expired_state", state,             S_EXPIRED);
        check("expired_decs",  dec_count - d_run, 24);
        check("expired_model", model,             0);
        check("dec_in_pause",  dec_in_pause,      0);
        blen      = 0;
        bad_buzz  = 0;
        bad_blank = 0;
        d0 = dec_count;
        for (int i = 0; i < 30; i++) begin
            if (i > 0) step();
            if (buzzer) blen++;
            if (buzzer !== (i < 20)) bad_buzz++;
`ifdef SHOT_CLOCK_BLINK_EN
            exp_blank = ((i / 5) % 2) == 0;
`else
            exp_blank = 1'b0;
`endif
            if (disp_blank !== exp_blank) bad_blank++;
        end
        check("buzz_len",     blen,           20);
        check("buzz_shape",   bad_buzz,       0);
        check("blank_shape",  bad_blank,      0);
        check("expired_no_dec", dec_count - d0, 0);

        // ---- start and pause are ignored in EXPIRED
        tap(0);
        repeat (20) step();
        check("exp_ign_start", state, S_EXPIRED);
        tap(1);
        repeat (20) step();
        check("exp_ign_pause", state, S_EXPIRED);

        // ---- load press leaves EXPIRED; blank and buzzer cleared
        tap(2);
        wait_state(S_LOAD, 40, n);
        check("exp_load_lat",    n,          PRESS_LAT);
        check("exp_load_blank",  disp_blank, 0);
        check("exp_load_buzzer", buzzer,     0);
        step();
        check("exp_reload_val", cnt_load_val, 24);
        check("exp_reload_str", cnt_load,     1);
        check("exp_to_idle",    state,        S_IDLE);
        repeat (20) step();

        // ---- bouncing start button: exactly one IDLE->RUN
        d0 = run_rises;
        for (int i = 0; i < 20; i++) begin
            start_n = ((i / 2) % 2) != 0;
            step();
        end
        check("bounce_no_early", state, S_IDLE);
        start_n = 1'b0;
        wait_state(S_RUN, 40, n);
        check("bounce_lat", n, PRESS_LAT);
        repeat (20) step();
        start_n = 1'b1;
        repeat (10) step();
        check("bounce_one_run", run_rises - d0, 1);
        check("bounce_state",   state,          S_RUN);

        // ---- load press during RUN at cnt_value=7, sw_sel=1
        sw_sel = 1'b1;
        n = 0;
        while (model !== 5'd7 && n < 400) begin
            step();
            n++;
        end
        check("reach_7", model, 7);
        tap(2);
        wait_state(S_LOAD, 40, n);
        check("run_load_lat",   n,     PRESS_LAT);
        check("run_load_at_7",  model, 7);
        step();
        check("run_load_str",   cnt_load,     1);
        check("run_load_val",   cnt_load_val, 30);
        check("run_load_idle",  state,        S_IDLE);
        d0 = dec_count;
        repeat (30) step();
        check("idle_no_dec",  dec_count - d0, 0);
        check("idle_model",   model,          30);
        check("idle_state",   state,          S_IDLE);

        // ---- prescaler was cleared: full second before the first strobe
        tap(0);
        wait_state(S_RUN, 40, n);
        check("restart_lat", n, PRESS_LAT);
        wait_dec(n);
        check("restart_first_dec", n, 10);

        // ---- asynchronous reset mid-run
        repeat (3) step();
        reset = 1'b0;
        #1;
        check("midrst_state",   state,        S_LOAD);
        check("midrst_run_led", run_led,      0);
        check("midrst_dec",     cnt_dec,      0);
        check("midrst_val",     cnt_load_val, 24);
        repeat (3) step();
        reset = 1'b1;
        step();
        check("midrst_reload",  cnt_load,     1);
        check("midrst_val_30",  cnt_load_val, 30);
        check("midrst_idle",    state,        S_IDLE);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/shot_clock_ctrl.md
# shot_clock_ctrl

Sequencing controller for the 24/30-second shot-clock countdown datapath on the DE10 board. Conditions the raw pushbuttons, generates the 1 Hz decrement strobe, and owns the load/run/pause/expire state machine. It drives the counter's load and decrement controls and a buzzer. The countdown register, BCD split and 7-segment decode stay downstream.

## Interface
Parameters:
- TICK_DIV, 50_000_000: clk cycles per second (one decrement); minimum 4, even.
- DEBOUNCE_CYC, 500_000: cycles a synchronized button level must be stable before it is accepted.
- BUZZ_SEC, 2: buzzer duration after expiry, in seconds.
- PRESET_A, 24: load value when sw_sel=0. PRESET_B, 30: load value when sw_sel=1. Both are 1..31.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-low.
- start_n  in  1  raw pushbutton, active-low, asynchronous.
- pause_n  in  1  raw pushbutton, active-low, asynchronous.
- load_n  in  1  raw pushbutton, active-low, asynchronous.
- sw_sel  in  1  preset select slide switch, asynchronous.
- cnt_value  in  5  current countdown value from the datapath.
- cnt_load  out  1  one-cycle strobe: datapath loads cnt_load_val.
- cnt_load_val  out  5  preset value, valid while cnt_load=1.
- cnt_dec  out  1  one-cycle strobe: datapath decrements by 1.
- buzzer  out  1  horn drive.
- disp_blank  out  1  request to blank the display.
- run_led  out  1  high in RUN.
- state  out  3  current FSM state code.

## Operation
- Button conditioning, applied to each button:
  - two-flop synchronizer;
  - debounce counter: accept a new level after DEBOUNCE_CYC consecutive equal samples;
  - press event = one-cycle pulse on the debounced 1→0 transition.
- sw_sel passes through a two-flop synchronizer only.
- States:
  - LOAD = 0: cnt_load=1, cnt_load_val = synced sw_sel ? PRESET_B : PRESET_A. Always goes to IDLE on the next cycle.
  - IDLE = 1: start press → RUN.
  - RUN = 2: pause press → PAUSED.
  - PAUSED = 3: start or pause press → RUN.
  - EXPIRED = 4: start and pause presses are ignored.
- A load press takes priority over every other event in every state (including LOAD) → LOAD.
- Prescaler, 0..TICK_DIV-1:
  - advances only in RUN;
  - cleared on IDLE→RUN and on entry to LOAD;
  - held through PAUSED, so resuming continues the partial second.
- Tick = prescaler at TICK_DIV-1 while in RUN. On a tick:
  - if cnt_value > 1: assert cnt_dec, stay in RUN;
  - if cnt_value == 1: assert cnt_dec, go to EXPIRED;
  - if cnt_value == 0: no cnt_dec, go to EXPIRED.
- A pause press in the same cycle as a tick: the tick's cnt_dec and any EXPIRED transition win; the pause is applied only if the state stays RUN.
- EXPIRED: buzzer=1 for exactly BUZZ_SEC*TICK_DIV cycles from entry, then 0. The state holds until a load press.
- run_led = (state == RUN).

## Timing
- Reset values:
  - state = LOAD.
  - All outputs are 0, except cnt_load_val = PRESET_A.
  - Debounced button levels = 1 (released); prescaler and buzzer counter = 0.
- First cycle after reset release: cnt_load=1 with cnt_load_val from synced sw_sel.
- All outputs are registered.
- Press latency: 2 sync cycles + DEBOUNCE_CYC + 1 cycle for the pulse. The state changes on the edge after the pulse.
- cnt_dec is high for exactly 1 cycle per tick. The first cnt_dec comes TICK_DIV cycles after entering RUN from IDLE.
- The datapath decrements on the same edge that samples cnt_dec. cnt_value is therefore one cycle stale relative to cnt_dec, and ticks are always ≥ TICK_DIV cycles apart.
- Reset asserted mid-operation: immediate return to reset values, regardless of state.

## Configuration
- SHOT_CLOCK_BLINK_EN defined:
  - in EXPIRED, disp_blank toggles every TICK_DIV/2 cycles, starting at 1 on the entry edge;
  - disp_blank is forced to 0 on leaving EXPIRED.
- Not defined: disp_blank is tied to 0 and no blink counter is synthesized.

## Structure
- Package shot_clock_pkg holds:
  - state codes LOAD/IDLE/RUN/PAUSED/EXPIRED;
  - default PRESET_A/PRESET_B;
  - the 5-bit count width constant.
- Sub-module btn_conditioner (synchronizer + debounce + falling-edge pulse, parameter DEBOUNCE_CYC) is instantiated three times.
- FSM, prescaler, buzzer counter and blink logic live in the top level.

## Test plan
All scenarios run with TICK_DIV=10, DEBOUNCE_CYC=4, BUZZ_SEC=2.
- Reset release with sw_sel=1 → cnt_load=1 for one cycle, cnt_load_val=30, then state=IDLE.
- Start press from IDLE, with the bench counter modeled → first cnt_dec 10 cycles after RUN entry, then every 10 cycles. After 24 strobes from preset 24: state=EXPIRED, buzzer=1 for exactly 20 cycles.
- Pause 4 cycles into a second, wait 50 cycles, resume → next cnt_dec 6 cycles after re-entering RUN; no cnt_dec while PAUSED.
- Button bounce: start_n toggling every 2 cycles for 20 cycles, then held low → exactly one press pulse, one IDLE→RUN transition.
- Load press during RUN at cnt_value=7 → LOAD with cnt_load_val from current sw_sel, prescaler cleared, IDLE; no cnt_dec afterwards.
- With SHOT_CLOCK_BLINK_EN: in EXPIRED, disp_blank toggles every 5 cycles; after a load press disp_blank=0. Without the macro: disp_blank stays 0 throughout.
